// File: rtl/orv64_itb_ctrl.sv
// orv64 instruction trace buffer: circular capture store with trigger/freeze control
// and a debug port. Define ORV64_ITB_PARITY_EN to add per-entry even parity and dbg_perr.
module orv64_itb_ctrl #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 256,
    parameter int  DROP_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [AW-1:0]     cfg_post_trig,
    input  logic              cfg_sleep,
    input  logic              clr,
    input  logic              trig,
    input  logic              tr_en,
    input  logic [DATA_W-1:0] tr_data,
    input  logic              dbg_en,
    input  logic              dbg_rw,
    input  logic [AW-1:0]     dbg_addr,
    input  logic [DATA_W-1:0] dbg_din,
    output logic [DATA_W-1:0] dbg_dout,
    output logic              dbg_dout_vld,
`ifdef ORV64_ITB_PARITY_EN
    output logic              dbg_perr,
`endif
    output logic [AW-1:0]     wr_ptr,
    output logic [AW-1:0]     oldest_ptr,
    output logic              wrapped,
    output logic              frozen,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef ORV64_ITB_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_POST,
        S_FROZEN
    } state_t;

    // The parity bit, when present, sits above the data bits of each entry.
    function automatic logic [MW-1:0] pack_entry(input logic [DATA_W-1:0] d);
`ifdef ORV64_ITB_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic               wrapped_q, wrapped_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0]  dout_q;
    logic               vld_q;
    logic [MW-1:0]      mem_q [DEPTH];
    logic [MW-1:0]      rd_entry;

    logic capture;
    logic dbg_req;
    logic tr_acc;
    logic tr_drop;

    always_comb begin
        capture = (state_q == S_RUN) || (state_q == S_POST);
        dbg_req = dbg_en && !cfg_sleep;
        // clr suppresses both the write and the drop count in its cycle.
        tr_acc  = capture && tr_en && !dbg_en && !cfg_sleep && !clr;
        tr_drop = capture && tr_en && (dbg_en || cfg_sleep) && !clr;

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wrapped_d  = wrapped_q;
        drop_d     = drop_q;
        post_cnt_d = post_cnt_q;

        if (tr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
                wrapped_d = 1'b1;
            end
        end
        if (tr_drop && !(&drop_q)) begin
            drop_d = drop_q + DROP_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (trig) begin
                    post_cnt_d = cfg_post_trig;
                    state_d    = (cfg_post_trig == '0) ? S_FROZEN : S_POST;
                end
            end
            S_POST: begin
                // Freeze on the write that uses up the last post-trigger slot.
                post_cnt_d = post_cnt_q - {{(AW-1){1'b0}}, tr_acc};
                if (post_cnt_d == '0) begin
                    state_d = S_FROZEN;
                end
            end
            default: state_d = state_q;
        endcase

        if (clr || !cfg_en) begin
            state_d = S_IDLE;
        end
        if (clr) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
            drop_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            wrapped_q  <= 1'b0;
            drop_q     <= '0;
            post_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wrapped_q  <= wrapped_d;
            drop_q     <= drop_d;
            post_cnt_q <= post_cnt_d;
        end
    end

    // Single write port: debug has priority, and a trace write never coincides with it.
    always_ff @(posedge clk) begin
        if (dbg_req && dbg_rw) begin
            mem_q[dbg_addr] <= pack_entry(dbg_din);
        end else if (tr_acc) begin
            mem_q[wr_ptr_q] <= pack_entry(tr_data);
        end
    end

    assign rd_entry = mem_q[dbg_addr];

`ifdef ORV64_ITB_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (dbg_req && !dbg_rw) begin
            perr_q <= rd_entry[DATA_W] != (^rd_entry[DATA_W-1:0]);
        end
    end

    assign dbg_perr = perr_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= dbg_req && !dbg_rw;
            if (dbg_req && !dbg_rw) begin
                dout_q <= rd_entry[DATA_W-1:0];
            end
        end
    end

    assign dbg_dout     = dout_q;
    assign dbg_dout_vld = vld_q;
    assign wr_ptr       = wr_ptr_q;
    assign oldest_ptr   = wrapped_q ? wr_ptr_q : '0;
    assign wrapped      = wrapped_q;
    assign frozen       = (state_q == S_FROZEN);
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_orv64_itb_ctrl.sv
// Bench for orv64_itb_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural trace-buffer model.
module tb_orv64_itb_ctrl;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_en;
    logic [AW-1:0]     cfg_post_trig;
    logic              cfg_sleep;
    logic              clr;
    logic              trig;
    logic              tr_en;
    logic [DATA_W-1:0] tr_data;
    logic              dbg_en;
    logic              dbg_rw;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_din;
    logic [DATA_W-1:0] dbg_dout;
    logic              dbg_dout_vld;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     oldest_ptr;
    logic              wrapped;
    logic              frozen;
    logic [DROP_W-1:0] drop_cnt;
`ifdef ORV64_ITB_PARITY_EN
    logic              dbg_perr;
`endif

    orv64_itb_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_en       (cfg_en),
        .cfg_post_trig(cfg_post_trig),
        .cfg_sleep    (cfg_sleep),
        .clr          (clr),
        .trig         (trig),
        .tr_en        (tr_en),
        .tr_data      (tr_data),
        .dbg_en       (dbg_en),
        .dbg_rw       (dbg_rw),
        .dbg_addr     (dbg_addr),
        .dbg_din      (dbg_din),
        .dbg_dout     (dbg_dout),
        .dbg_dout_vld (dbg_dout_vld),
`ifdef ORV64_ITB_PARITY_EN
        .dbg_perr     (dbg_perr),
`endif
        .wr_ptr       (wr_ptr),
        .oldest_ptr   (oldest_ptr),
        .wrapped      (wrapped),
        .frozen       (frozen),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          tr_en;
        bit          dbg_en;
        bit          dbg_rw;
        logic [7:0]  addr;
        logic [63:0] data;
        int          exp_ptr;
        bit          exp_vld;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t vecs [16];

    // Behavioural model: a flat array plus a running count of writes since clr.
    logic [63:0] m_mem [DEPTH];
    int          m_total;
    int          m_drop;
    bit          m_on;
    bit          m_frz;
    int          m_left;
    logic [63:0] m_dout;
    bit          m_vld;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cfg_post_trig = '0;
        cfg_sleep     = 1'b0;
        clr           = 1'b0;
        trig          = 1'b0;
        tr_en         = 1'b0;
        tr_data       = '0;
        dbg_en        = 1'b0;
        dbg_rw        = 1'b0;
        dbg_addr      = '0;
        dbg_din       = '0;
    endtask

    task automatic clr_then_run();
        idle_inputs();
        cfg_en = 1'b1;
        clr    = 1'b1;
        tick();
        clr    = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        m_total = 0;
        m_drop  = 0;
        m_on    = 1'b0;
        m_frz   = 1'b0;
        m_left  = -1;
        m_dout  = '0;
        m_vld   = 1'b0;
    endtask

    task automatic model_step();
        bit cap;
        cap = m_on && !m_frz;
        if (clr) begin
            m_total = 0;
            m_drop  = 0;
            m_on    = 1'b0;
            m_frz   = 1'b0;
            m_left  = -1;
        end else begin
            if (cap && tr_en) begin
                if (dbg_en || cfg_sleep) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_mem[m_total % DEPTH] = tr_data;
                    m_total++;
                    if (m_left > 0) m_left--;
                end
            end
            if (cap && trig && m_left < 0) m_left = int'(cfg_post_trig);
            if (m_left == 0) m_frz = 1'b1;
            if (!m_on && cfg_en) m_on = 1'b1;
            if (!cfg_en) begin
                m_on   = 1'b0;
                m_frz  = 1'b0;
                m_left = -1;
            end
        end
        if (dbg_en && !cfg_sleep) begin
            if (dbg_rw) m_mem[dbg_addr] = dbg_din;
            else        m_dout = m_mem[dbg_addr];
            m_vld = !dbg_rw;
        end else begin
            m_vld = 1'b0;
        end
    endtask

    task automatic step_and_compare();
        model_step();
        tick();
        chk("rnd_wr_ptr", 64'(wr_ptr), 64'(m_total % DEPTH));
        chk("rnd_wrapped", 64'(wrapped), 64'(m_total >= DEPTH));
        chk("rnd_oldest", 64'(oldest_ptr), (m_total >= DEPTH) ? 64'(m_total % DEPTH) : 64'd0);
        chk("rnd_frozen", 64'(frozen), 64'(m_frz));
        chk("rnd_drop", 64'(drop_cnt), 64'(m_drop));
        chk("rnd_vld", 64'(dbg_dout_vld), 64'(m_vld));
        chk("rnd_dout", dbg_dout, m_dout);
`ifdef ORV64_ITB_PARITY_EN
        chk("rnd_perr", 64'(dbg_perr), 64'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{tr_en: 1'b1, dbg_en: 1'b0, dbg_rw: 1'b0, addr: 8'd0,
                        data: 64'h100 + 64'(i), exp_ptr: i + 1, exp_vld: 1'b0, exp_dout: 64'd0};
        end
        vecs[10] = '{tr_en: 1'b0, dbg_en: 1'b1, dbg_rw: 1'b0, addr: 8'd3,
                     data: 64'd0, exp_ptr: 10, exp_vld: 1'b1, exp_dout: 64'h103};
        for (int i = 11; i < 16; i++) begin
            vecs[i] = '{tr_en: 1'b0, dbg_en: 1'b0, dbg_rw: 1'b0, addr: 8'd0,
                        data: 64'd0, exp_ptr: 10, exp_vld: 1'b0, exp_dout: 64'h103};
        end

        // Reset values
        rst    = 1'b0;
        cfg_en = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        chk("rst_wrapped", 64'(wrapped), 64'd0);
        chk("rst_frozen", 64'(frozen), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_dout", dbg_dout, 64'd0);
        chk("rst_vld", 64'(dbg_dout_vld), 64'd0);
        rst    = 1'b1;
        cfg_en = 1'b1;
        tick();

        // Directed table: 10 writes, read back, hold
        for (int i = 0; i < 16; i++) begin
            tr_en    = vecs[i].tr_en;
            tr_data  = vecs[i].data;
            dbg_en   = vecs[i].dbg_en;
            dbg_rw   = vecs[i].dbg_rw;
            dbg_addr = vecs[i].addr;
            tick();
            chk($sformatf("vec%0d_ptr", i), 64'(wr_ptr), 64'(vecs[i].exp_ptr));
            chk($sformatf("vec%0d_vld", i), 64'(dbg_dout_vld), 64'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_dout", i), dbg_dout, vecs[i].exp_dout);
        end
        chk("vec_wrapped", 64'(wrapped), 64'd0);

        // Wrap: 260 writes
        clr_then_run();
        for (int i = 0; i < 260; i++) begin
            tr_en   = 1'b1;
            tr_data = 64'(i);
            tick();
        end
        tr_en = 1'b0;
        chk("wrap_ptr", 64'(wr_ptr), 64'd4);
        chk("wrap_flag", 64'(wrapped), 64'd1);
        chk("wrap_oldest", 64'(oldest_ptr), 64'd4);
        dbg_en   = 1'b1;
        dbg_addr = 8'd0;
        tick();
        dbg_en = 1'b0;
        chk("wrap_rd0", dbg_dout, 64'd256);

        // Post-trigger freeze after exactly 5 writes
        clr_then_run();
        chk("clr_wrapped", 64'(wrapped), 64'd0);
        for (int i = 0; i < 20; i++) begin
            tr_en   = 1'b1;
            tr_data = 64'h3000 + 64'(i);
            tick();
        end
        tr_en         = 1'b0;
        trig          = 1'b1;
        cfg_post_trig = 8'd5;
        tick();
        trig = 1'b0;
        chk("post_not_frozen", 64'(frozen), 64'd0);
        for (int i = 20; i < 30; i++) begin
            tr_en   = 1'b1;
            tr_data = 64'h3000 + 64'(i);
            tick();
        end
        tr_en = 1'b0;
        chk("post_ptr", 64'(wr_ptr), 64'd25);
        chk("post_frozen", 64'(frozen), 64'd1);
        chk("post_drop", 64'(drop_cnt), 64'd0);

        // Debug write/read while frozen, then clr
        dbg_en   = 1'b1;
        dbg_rw   = 1'b1;
        dbg_addr = 8'd7;
        dbg_din  = 64'hDEAD;
        tick();
        dbg_rw = 1'b0;
        tick();
        dbg_en = 1'b0;
        chk("frz_rd_dout", dbg_dout, 64'hDEAD);
        chk("frz_rd_vld", 64'(dbg_dout_vld), 64'd1);
        chk("frz_still", 64'(frozen), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ptr", 64'(wr_ptr), 64'd0);
        chk("clr_frozen", 64'(frozen), 64'd0);
        tr_en = 1'b1;
        tick();
        chk("idle_ignores_wr", 64'(wr_ptr), 64'd0);

        // Drop counter saturation
        dbg_en   = 1'b1;
        dbg_rw   = 1'b0;
        dbg_addr = 8'd0;
        for (int i = 0; i < 300; i++) tick();
        tr_en  = 1'b0;
        dbg_en = 1'b0;
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        chk("sat_ptr", 64'(wr_ptr), 64'd0);

        // Sleep blocks debug and drops trace
        clr_then_run();
        dbg_en   = 1'b1;
        dbg_addr = 8'd3;
        tick();
        chk("pre_sleep_dout", dbg_dout, 64'h3003);
        cfg_sleep = 1'b1;
        dbg_addr  = 8'd7;
        tr_en     = 1'b1;
        tick();
        chk("sleep_vld", 64'(dbg_dout_vld), 64'd0);
        chk("sleep_dout", dbg_dout, 64'h3003);
        chk("sleep_drop", 64'(drop_cnt), 64'd1);
        chk("sleep_ptr", 64'(wr_ptr), 64'd0);
        idle_inputs();

`ifdef ORV64_ITB_PARITY_EN
        dbg_en   = 1'b1;
        dbg_rw   = 1'b1;
        dbg_addr = 8'd5;
        dbg_din  = 64'h1234;
        tick();
        dut.mem_q[5][0] = ~dut.mem_q[5][0];
        dbg_rw = 1'b0;
        tick();
        chk("perr_flag", 64'(dbg_perr), 64'd1);
        chk("perr_vld", 64'(dbg_dout_vld), 64'd1);
        dbg_addr = 8'd6;
        tick();
        chk("perr_clean", 64'(dbg_perr), 64'd0);
        idle_inputs();
`endif

        // Async reset mid-POST
        clr_then_run();
        for (int i = 0; i < 3; i++) begin
            tr_en   = 1'b1;
            tr_data = 64'h6000 + 64'(i);
            tick();
        end
        dbg_en = 1'b1;
        tick();
        dbg_en        = 1'b0;
        tr_en         = 1'b0;
        trig          = 1'b1;
        cfg_post_trig = 8'd10;
        tick();
        trig  = 1'b0;
        tr_en = 1'b1;
        tick();
        tr_en  = 1'b0;
        dbg_en = 1'b1;
        tick();
        dbg_en = 1'b0;
        chk("prerst_vld", 64'(dbg_dout_vld), 64'd1);
        chk("prerst_dout", dbg_dout, 64'h6000);
        #2 rst = 1'b0;
        #1;
        chk("arst_ptr", 64'(wr_ptr), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_dout", dbg_dout, 64'd0);
        chk("arst_vld", 64'(dbg_dout_vld), 64'd0);
        chk("arst_frozen", 64'(frozen), 64'd0);
        tick();
        rst = 1'b1;
        model_reset();

        // Randomized traffic against the model, after initializing every entry
        cfg_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs();
            dbg_en   = 1'b1;
            dbg_rw   = 1'b1;
            dbg_addr = AW'(i);
            dbg_din  = {$urandom, $urandom};
            step_and_compare();
        end
        for (int i = 0; i < 3000; i++) begin
            cfg_en        = ($urandom_range(0, 99) < 97);
            clr           = ($urandom_range(0, 99) < 2);
            trig          = ($urandom_range(0, 99) < 6);
            cfg_post_trig = AW'($urandom_range(0, 12));
            cfg_sleep     = ($urandom_range(0, 99) < 8);
            tr_en         = ($urandom_range(0, 99) < 70);
            tr_data       = {$urandom, $urandom};
            dbg_en        = ($urandom_range(0, 99) < 20);
            dbg_rw        = $urandom_range(0, 1) == 1;
            dbg_addr      = AW'($urandom_range(0, DEPTH - 1));
            dbg_din       = {$urandom, $urandom};
            step_and_compare();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/orv64_itb_ctrl.md
Name: orv64_itb_ctrl

Overview:
Parametrised instruction trace buffer: circular capture store with integrated write-pointer management, trigger/post-trigger freeze control, and a debug read/write port with registered, held read data. Sits between the orv64 retire stage (trace writer) and the debug module (reader). Storage is an internal flop array of DEPTH x DATA_W.

Parameters:
DATA_W, 64, trace entry width in bits
DEPTH, 256, entries; power of 2, at least 4; AW = $clog2(DEPTH)
DROP_W, 8, width of saturating dropped-entry counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cfg_en  in  1  capture enable; 0 forces IDLE
cfg_post_trig  in  AW  entries captured after trigger before freeze
cfg_sleep  in  1  storage sleep; blocks all accesses, outputs held
clr  in  1  synchronous clear of pointer, flags, counter; state to IDLE
trig  in  1  trigger pulse
tr_en  in  1  trace write request
tr_data  in  DATA_W  trace entry
dbg_en  in  1  debug access request
dbg_rw  in  1  1 = write, 0 = read
dbg_addr  in  AW  physical entry index
dbg_din  in  DATA_W  debug write data
dbg_dout  out  DATA_W  debug read data
dbg_dout_vld  out  1  one-cycle pulse, read data updated
wr_ptr  out  AW  next physical write index
oldest_ptr  out  AW  wrapped ? wr_ptr : 0
wrapped  out  1  buffer has wrapped at least once
frozen  out  1  state == FROZEN
drop_cnt  out  DROP_W  trace writes lost

Behaviour:
- Reset (rst low, async): wr_ptr=0, wrapped=0, drop_cnt=0, state IDLE, dbg_dout=0, dbg_dout_vld=0; array contents undefined.
- States: IDLE -> RUN when cfg_en=1. RUN -> POST on trig (counter loaded with cfg_post_trig). POST -> FROZEN when counter is 0 and no write is pending; counter decrements per accepted write. cfg_post_trig=0: RUN -> FROZEN on trig directly, and the trig-cycle write is still accepted. FROZEN holds until clr or cfg_en=0. Any state -> IDLE on cfg_en=0 or clr; pointer/flags are cleared by clr only.
- trig in POST or FROZEN: ignored.
- Trace write accepted when state in {RUN, POST}, tr_en=1, dbg_en=0, cfg_sleep=0: array[wr_ptr] <= tr_data; wr_ptr increments modulo DEPTH; wrapped sets on the DEPTH-1 -> 0 transition and stays set.
- tr_en=1 in RUN/POST with dbg_en=1 or cfg_sleep=1: write dropped, drop_cnt += 1, saturating at all-ones. tr_en in IDLE/FROZEN: ignored, not counted.
- Debug port has priority over trace port; it is usable in every state.
- Debug write: array[dbg_addr] <= dbg_din on the same edge; pointer unaffected.
- Debug read issued in cycle N: dbg_dout = array[dbg_addr] and dbg_dout_vld=1 in cycle N+1; dbg_dout then holds until the next read completes.
- Debug read in the same cycle as a write to the same address cannot occur (single port; debug excludes trace).
- cfg_sleep=1: debug requests ignored (no vld), dbg_dout held.
- clr and trig together: clr wins. clr and tr_en together: no write, no drop count.

Optional Feature:
ORV64_ITB_PARITY_EN: when defined, each entry stores an extra even-parity bit computed on write (trace or debug). An output dbg_perr (1 bit) asserts together with dbg_dout_vld if the read parity mismatches; it resets to 0 and holds with dbg_dout. When not defined, there is no parity storage and no dbg_perr port.

Test Plan:
- Reset, cfg_en=1, 10 tr_en writes of 0x100+i -> wr_ptr=10, wrapped=0; debug read addr 3 -> next-cycle dbg_dout=0x103, vld pulse, value held 5 idle cycles.
- DEPTH=256, 260 writes -> wr_ptr=4, wrapped=1, oldest_ptr=4; read addr 0 returns entry 256.
- cfg_post_trig=5, trig after 20 writes, continuous tr_en -> exactly 5 further writes, frozen=1, wr_ptr=25; further tr_en leaves wr_ptr=25, drop_cnt=0.
- tr_en and dbg_en read held together for 300 cycles in RUN -> drop_cnt saturates at 255, wr_ptr unchanged.
- Debug write 0xDEAD to addr 7 in FROZEN, then read -> 0xDEAD; clr -> wr_ptr=0, wrapped=0, state IDLE.
- rst asserted mid-POST -> all outputs return to reset values immediately; with ORV64_ITB_PARITY_EN, a forced array bit flip before read -> dbg_perr=1 with vld.
